button_conditioner: RTL

//  Conditions the four raw push-button pins for the game FSM: two-flop synchroniser,
//  per-button debounce, single-owner chord arbitration, and optional auto-repeat.

---
 rtl/button_conditioner.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/button_conditioner.sv
// Purpose: condition four raw push-button pins for the game FSM. The path is a
//          two-flop synchroniser, a per-button debounce, arbitration that gives
//          one button ownership of the outputs, and optional auto-repeat.
// Ports:
//   clk        - clock
//   rst_n      - synchronous active-low reset
//   btn_raw    - async active-high pins: [0]=up [1]=right [2]=down [3]=left
//   btn_up     - conditioned up level
//   btn_right  - conditioned right level
//   btn_down   - conditioned down level
//   btn_left   - conditioned left level
//   btn_event  - one-cycle pulse in the cycle any output rises
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned REPEAT_DELAY    = 0,
  parameter int unsigned REPEAT_PERIOD   = 10000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn_raw,
  output logic       btn_up,
  output logic       btn_right,
  output logic       btn_down,
  output logic       btn_left,
  output logic       btn_event
);

  localparam int unsigned CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HELD    = 2'd1;
  localparam logic [1:0] ST_GAP     = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] RPT_LATER = RPT_W'(REPEAT_PERIOD);

  logic [3:0]       sync1_q, sync2_q;
  logic [3:0]       stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];

  logic [1:0]       state_q, state_d;
  logic [1:0]       owner_q, owner_d;
  logic [3:0]       out_q, out_d;
  logic             event_q, event_d;
  logic [RPT_W-1:0] rpt_q, rpt_d;
  logic             first_q, first_d;
  logic [RPT_W-1:0] rpt_inc;
  logic [1:0]       pick;

  // Two-flop synchroniser; only sync2 feeds the debounce.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: a bit flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stable_q <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      stable_q <= stable_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Priority pick left > right > up > down among stable presses.
  always_comb begin
    if (stable_q[3])      pick = 2'd3;
    else if (stable_q[1]) pick = 2'd1;
    else if (stable_q[0]) pick = 2'd0;
    else                  pick = 2'd2;
  end

  assign rpt_inc = rpt_q + RPT_W'(1);

  // Arbitration / auto-repeat next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    out_d   = '0;
    event_d = 1'b0;
    rpt_d   = rpt_q;
    first_d = first_q;
    case (state_q)
      ST_IDLE: begin
        if (stable_q != 4'b0000) begin
          owner_d = pick;
          state_d = ST_HELD;
          out_d   = 4'b0001 << pick;
          event_d = 1'b1;
          rpt_d   = '0;
          first_d = 1'b1;
        end
      end
      ST_HELD: begin
        if (!stable_q[owner_q]) begin
          // Owner let go: any other still-pressed button is a chord remnant.
          rpt_d   = '0;
          state_d = (stable_q == 4'b0000) ? ST_IDLE : ST_RELEASE;
        end else begin
          out_d = 4'b0001 << owner_q;
          if (REPEAT_DELAY != 0) begin
            if (rpt_inc == (first_q ? RPT_FIRST : RPT_LATER)) begin
              state_d = ST_GAP;
              out_d   = '0;
              rpt_d   = '0;
              first_d = 1'b0;
            end else begin
              rpt_d = rpt_inc;
            end
          end
        end
      end
      ST_GAP: begin
        rpt_d = '0;
        if (stable_q[owner_q]) begin
          state_d = ST_HELD;
          out_d   = 4'b0001 << owner_q;
          event_d = 1'b1;
        end else begin
          state_d = (stable_q == 4'b0000) ? ST_IDLE : ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (stable_q == 4'b0000) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= 2'd0;
      out_q   <= '0;
      event_q <= 1'b0;
      rpt_q   <= '0;
      first_q <= 1'b1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      out_q   <= out_d;
      event_q <= event_d;
      rpt_q   <= rpt_d;
      first_q <= first_d;
    end
  end

  assign btn_up    = out_q[0];
  assign btn_right = out_q[1];
  assign btn_down  = out_q[2];
  assign btn_left  = out_q[3];
  assign btn_event = event_q;

endmodule
